// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit: lane extract/extend on loads, read-modify-write for sb/sh.
// Optional misalignment trap: define RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_done,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_word;
  logic              err_q;

  logic              f3_legal;
  logic              misaligned;
  logic              req_err;
  logic [MEM_AW-1:0] word_addr;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_result;
  logic [31:0]       merged;

  assign word_addr = addr_q[MEM_AW+1:2];

  // Stores only have b/h/w encodings; the unsigned variants are load-only.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_store;
      default:                f3_legal = 1'b0;
    endcase
  end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = !f3_legal || misaligned;

  always_comb begin
    rd_byte = mem_rd[7:0];
    case (addr_q[1:0])
      2'b00: rd_byte = mem_rd[7:0];
      2'b01: rd_byte = mem_rd[15:8];
      2'b10: rd_byte = mem_rd[23:16];
      2'b11: rd_byte = mem_rd[31:24];
      default: rd_byte = mem_rd[7:0];
    endcase
    rd_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (f3_q)
      3'b000:  ld_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_result = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_result = {24'h0, rd_byte};
      3'b101:  ld_result = {16'h0, rd_half};
      default: ld_result = mem_rd;
    endcase
  end

  // wr_word still holds the latched rs2 while in RD_DATA, so its low lanes are the new data.
  always_comb begin
    merged = mem_rd;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00: merged[7:0]   = wr_word[7:0];
        2'b01: merged[15:8]  = wr_word[7:0];
        2'b10: merged[23:16] = wr_word[7:0];
        2'b11: merged[31:24] = wr_word[7:0];
        default: merged = mem_rd;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wr_word[15:0];
    end else begin
      merged[15:0] = wr_word[15:0];
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_done  = 1'b0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wd    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_nxt = DONE;
          else if (req_store && req_funct3 == 3'b010)
            state_nxt = WR;
          else
            state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        mem_addr  = word_addr;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        mem_addr  = word_addr;
        state_nxt = store_q ? WR : DONE;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wd    = wr_word;
        state_nxt = DONE;
      end
      DONE: begin
        rsp_done  = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wr_word   <= '0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wr_word <= req_wdata;
        err_q   <= req_err;
      end
      if (state == RD_DATA) begin
        if (store_q)
          wr_word <= merged;
        else
          rsp_rdata <= ld_result;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu with a synchronous-read word memory model.
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  riscv_lsu #(.ADDR_W(32), .MEM_AW(30)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (mem_we)
      mem[mem_addr[5:0]] <= mem_wd;
    mem_rd <= mem[mem_addr[5:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      we_cnt = 0;
    end else begin
      if (mem_we) we_cnt++;
      if (rsp_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("latency", cyc - e.acc, e.lat);
          check("mem_we_cycles", we_cnt, e.we);
        end
        we_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive_accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output bit ok, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    acc = cyc;
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end
  endtask

  task automatic scramble(input logic st);
    #1;
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b011;
    req_addr = 32'hffff_fffc; req_wdata = 32'h0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, input int we);
    exp_t e;
    bit   ok;
    int   acc;
    drive_accept(st, f3, a, wd, ok, acc);
    if (ok) begin
      e.rdata = er; e.err = ee; e.lat = lat; e.we = we; e.acc = acc;
      sb_q.push_back(e);
      @(posedge clk);
      scramble(st);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1; break; end
      end
      if (!ok) check("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bd_we = 1'b0; bd_addr = 6'h0; bd_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_done", {31'd0, rsp_done}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    preload(6'd3, 32'hdeadbeef);
    issue(1'b0, 3'b001, 32'hC, 32'h0, 32'hffffbeef, 1'b0, 3, 0);
    issue(1'b0, 3'b101, 32'hE, 32'h0, 32'h0000dead, 1'b0, 3, 0);

    preload(6'd3, 32'hc001c0de);
    issue(1'b0, 3'b000, 32'hD, 32'h0, 32'hffffffc0, 1'b0, 3, 0);
    issue(1'b0, 3'b100, 32'hF, 32'h0, 32'h000000c0, 1'b0, 3, 0);
    issue(1'b0, 3'b010, 32'hC, 32'h0, 32'hc001c0de, 1'b0, 3, 0);

    preload(6'd4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h11, 32'h123456ab, 32'hc001c0de, 1'b0, 4, 1);
    check("mem_after_sb", mem[4], 32'h1122ab44);
    issue(1'b1, 3'b001, 32'h12, 32'h5555beef, 32'hc001c0de, 1'b0, 4, 1);
    check("mem_after_sh", mem[4], 32'hbeefab44);

    preload(6'd9, 32'h5a5a5a5a);
    issue(1'b1, 3'b010, 32'h20, 32'hcafef00d, 32'hc001c0de, 1'b0, 2, 1);
    check("mem_after_sw", mem[8], 32'hcafef00d);
    issue(1'b1, 3'b011, 32'h24, 32'h12345678, 32'hc001c0de, 1'b1, 1, 0);
    check("mem_after_err", mem[9], 32'h5a5a5a5a);

    // sb aborted by reset while in RD_DATA
    drive_accept(1'b1, 3'b000, 32'h11, 32'h00000077, ok, acc);
    if (ok) begin
      @(posedge clk);
      scramble(1'b1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("abort_rsp_done", {31'd0, rsp_done}, 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'h0);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_mem", mem[4], 32'hbeefab44);
    end

    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hbeefab44, 1'b0, 3, 0);
    issue(1'b0, 3'b100, 32'h12, 32'h0, 32'h000000ef, 1'b0, 3, 0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b001, 32'hD, 32'h0, 32'h000000ef, 1'b1, 1, 0);
`else
    issue(1'b0, 3'b001, 32'hD, 32'h0, 32'hffffc0de, 1'b0, 3, 0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
